// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_t : transaction FSM encoding (IDLE -> REQ -> RSP -> DONE)
//   owner_t     : which requester owns the outstanding transaction
//   MEM_MASK_*  : byte-mask constants; IFU fetches always read a full word
package ysyx_22041211_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2,
        ST_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [7:0] MEM_MASK_NONE = 8'h00;
    localparam logic [7:0] MEM_MASK_WORD = 8'h0F;
    localparam logic [7:0] IFU_RMASK     = MEM_MASK_WORD;

endpackage

// File: rtl/ysyx_22041211_arb_pick.sv
// Two-way request picker for the data-memory arbiter.
// Configuration macro: MEM_ARB_RR_EN
//   undefined : LSU wins every tie (fixed priority)
//   defined   : on a tie the requester that did not own the previous
//               transaction wins (last_owner supplied by the top)
// Ports:
//   ifu_valid, lsu_valid : pending requests
//   last_owner           : previous winner (round-robin build only)
//   grant                : at least one request present
//   pick                 : winning requester (meaningful when grant=1)
module ysyx_22041211_arb_pick
    import ysyx_22041211_mem_arbiter_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
`ifdef MEM_ARB_RR_EN
    input  owner_t last_owner,
`endif
    output logic   grant,
    output owner_t pick
);

    always_comb begin
        grant = ifu_valid | lsu_valid;
        pick  = OWN_LSU;
        if (ifu_valid && !lsu_valid) begin
            pick = OWN_IFU;
        end else if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            pick = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
`else
            pick = OWN_LSU;
`endif
        end
    end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares the single data-memory port between IFU (fetch) and LSU (load/store).
// One transaction is outstanding at a time.
// Configuration macro: MEM_ARB_RR_EN (round-robin tie break; default is fixed
// LSU priority).
//
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both 1; a valid source holds its payload stable
// until that edge.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   ifu_req_* / ifu_addr         IFU fetch request (ready pulses on grant)
//   ifu_rsp_* / ifu_rdata        IFU fetch response
//   lsu_req_* / lsu_wen/addr/wdata/wmask/rmask   LSU request
//   lsu_rsp_* / lsu_rdata        LSU response (rdata=0 for store ack)
//   mem_req_* / mem_wen/addr/wdata/wmask/rmask   latched request to SRAM
//   mem_rsp_* / mem_rdata        SRAM response
//   err_o                        sticky watchdog error (cleared by rst only)
//   dbg_state                    current FSM state
module ysyx_22041211_mem_arbiter
    import ysyx_22041211_mem_arbiter_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [7:0]          lsu_wmask,
    input  logic [7:0]          lsu_rmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [7:0]          mem_wmask,
    output logic [7:0]          mem_rmask,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                err_o,
    output arb_state_t          dbg_state
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam bit         WD_EN       = (TIMEOUT != 0);

    arb_state_t          state_q, state_d;
    owner_t              owner_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic                err_q;
    logic [7:0]          wd_cnt;
    logic [7:0]          wd_inc;
    logic                wd_hit;
    logic                grant;
    owner_t              pick;
    logic                owner_rsp_ready;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;
`endif

    ysyx_22041211_arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
        .last_owner (last_owner),
`endif
        .grant      (grant),
        .pick       (pick)
    );

    // The counter holds the number of RSP cycles already spent; the cycle
    // whose increment reaches TIMEOUT is the last RSP cycle. A real response
    // in that same cycle still wins.
    assign wd_inc = (wd_cnt == 8'hFF) ? 8'hFF : wd_cnt + 8'd1;
    assign wd_hit = WD_EN && (state_q == ST_RSP) && !mem_rsp_valid
                    && (wd_inc >= TIMEOUT_CNT);

    assign owner_rsp_ready = (owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant && !rst)                state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)                state_d = ST_RSP;
            ST_RSP:  if (mem_rsp_valid || wd_hit)      state_d = ST_DONE;
            ST_DONE: if (owner_rsp_ready)              state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IFU;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= MEM_MASK_NONE;
            mem_rmask <= MEM_MASK_NONE;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            wd_cnt    <= 8'd0;
`ifdef MEM_ARB_RR_EN
            last_owner <= OWN_IFU;
`endif
        end else begin
            state_q <= state_d;

            if (state_q == ST_IDLE && grant) begin
                owner_q <= pick;
`ifdef MEM_ARB_RR_EN
                last_owner <= pick;
`endif
                if (pick == OWN_LSU) begin
                    mem_wen   <= lsu_wen;
                    mem_addr  <= lsu_addr;
                    mem_wdata <= lsu_wdata;
                    mem_wmask <= lsu_wmask;
                    mem_rmask <= lsu_rmask;
                end else begin
                    mem_wen   <= 1'b0;
                    mem_addr  <= ifu_addr;
                    mem_wdata <= '0;
                    mem_wmask <= MEM_MASK_NONE;
                    mem_rmask <= IFU_RMASK;
                end
            end

            if (state_q == ST_REQ && mem_req_ready) begin
                wd_cnt <= 8'd0;
            end else if (state_q == ST_RSP) begin
                wd_cnt <= wd_inc;
            end

            if (state_q == ST_RSP) begin
                if (mem_rsp_valid) begin
                    rdata_q <= mem_wen ? '0 : mem_rdata;
                end else if (wd_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    // Grant is combinational so the winner sees ready in the same IDLE cycle
    // its valid is seen; rst masks it so no handshake appears during reset.
    assign ifu_req_ready = !rst && (state_q == ST_IDLE) && grant && (pick == OWN_IFU);
    assign lsu_req_ready = !rst && (state_q == ST_IDLE) && grant && (pick == OWN_LSU);

    assign mem_req_valid = (state_q == ST_REQ);
    assign mem_rsp_ready = (state_q == ST_RSP);

    assign ifu_rsp_valid = (state_q == ST_DONE) && (owner_q == OWN_IFU);
    assign lsu_rsp_valid = (state_q == ST_DONE) && (owner_q == OWN_LSU);
    assign ifu_rdata     = (owner_q == OWN_IFU) ? rdata_q : '0;
    assign lsu_rdata     = (owner_q == OWN_LSU) ? rdata_q : '0;

    assign err_o     = err_q;
    assign dbg_state = state_q;

endmodule
